// File: rtl/sub_8bit_seq_if.sv
// Operand/result bundle for sub_8bit_seq.
// With SUB8_OVF_FLAG_EN defined the bundle also carries the signed-overflow flag ovf.
interface sub_8bit_seq_if;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       borrow_start;
    logic [7:0] diff;
    logic       borrow;
    logic       busy;
    logic       done;
`ifdef SUB8_OVF_FLAG_EN
    logic       ovf;

    modport master (output start, a, b, borrow_start,
                    input  diff, borrow, busy, done, ovf);
    modport slave  (input  start, a, b, borrow_start,
                    output diff, borrow, busy, done, ovf);
`else
    modport master (output start, a, b, borrow_start,
                    input  diff, borrow, busy, done);
    modport slave  (input  start, a, b, borrow_start,
                    output diff, borrow, busy, done);
`endif
endinterface

// File: rtl/sub_8bit_seq.sv
// 8-bit subtractor evaluated as two 4-bit ripple passes (low nibble, then high nibble).
// Optional feature: define SUB8_OVF_FLAG_EN to add the registered signed-overflow output ovf.
module sub_8bit_seq (
    input  logic          clk,
    input  logic          rst,
    sub_8bit_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

    state_t     state_q, state_d;
    logic [7:0] a_q, a_d;
    logic [7:0] b_q, b_d;
    logic       bin_q, bin_d;
    logic [3:0] lo_q, lo_d;
    logic       nib_borrow_q, nib_borrow_d;
    logic [7:0] diff_q, diff_d;
    logic       borrow_q, borrow_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       ovf_q, ovf_d;
    logic [4:0] lo_res, hi_res;

    // Four chained full-subtractor cells; result is {borrow_out, difference}.
    function automatic logic [4:0] sub4(input logic [3:0] x, input logic [3:0] y, input logic bin);
        logic [3:0] d;
        logic       c;
        c = bin;
        for (int i = 0; i < 4; i++) begin
            d[i] = x[i] ^ y[i] ^ c;
            c    = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & c);
        end
        return {c, d};
    endfunction

    always_comb begin
        // NOTE: every variable gets its hold value first so no path through the case infers a latch.
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        bin_d        = bin_q;
        lo_d         = lo_q;
        nib_borrow_d = nib_borrow_q;
        diff_d       = diff_q;
        borrow_d     = borrow_q;
        ovf_d        = ovf_q;
        lo_res       = sub4(a_q[3:0], b_q[3:0], bin_q);
        hi_res       = sub4(a_q[7:4], b_q[7:4], nib_borrow_q);

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    bin_d   = bus.borrow_start;
                    state_d = LOW;
                end
            end
            LOW: begin
                lo_d         = lo_res[3:0];
                nib_borrow_d = lo_res[4];
                state_d      = HIGH;
            end
            HIGH: begin
                // diff, borrow and ovf are loaded together so no half-updated result is ever visible.
                diff_d   = {hi_res[3:0], lo_q};
                borrow_d = hi_res[4];
                ovf_d    = (a_q[7] != b_q[7]) && (hi_res[3] != a_q[7]);
                state_d  = DONE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == LOW) || (state_d == HIGH);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        // NOTE: operand and nibble registers are cleared on reset too, so nothing from an aborted run leaks out.
        if (rst) begin
            state_q      <= IDLE;
            a_q          <= '0;
            b_q          <= '0;
            bin_q        <= 1'b0;
            lo_q         <= '0;
            nib_borrow_q <= 1'b0;
            diff_q       <= '0;
            borrow_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            bin_q        <= bin_d;
            lo_q         <= lo_d;
            nib_borrow_q <= nib_borrow_d;
            diff_q       <= diff_d;
            borrow_q     <= borrow_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            ovf_q        <= ovf_d;
        end
    end

    assign bus.diff   = diff_q;
    assign bus.borrow = borrow_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
`ifdef SUB8_OVF_FLAG_EN
    assign bus.ovf    = ovf_q;
`else
    logic unused_ovf;
    assign unused_ovf = ovf_q;
`endif
endmodule

// File: doc/sub_8bit_seq.md
SUB_8BIT_SEQ -- requirements
Module: sub_8bit_seq

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state SHALL change only on the rising edge of clk.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 start  input  1  request to begin one subtraction, sampled at a rising clk edge.
REQ-005 a  input  8  minuend, unsigned or two's complement.
REQ-006 b  input  8  subtrahend.
REQ-007 borrow_start  input  1  borrow into bit 0.
REQ-008 diff  output  8  registered result a - b - borrow_start, modulo 256.
REQ-009 borrow  output  1  registered borrow out of bit 7; 1 when a < b + borrow_start, unsigned.
REQ-010 busy  output  1  high in states LOW and HIGH.
REQ-011 done  output  1  single-cycle pulse that marks a new diff/borrow.

Function
REQ-012 The FSM SHALL have four states, IDLE, LOW, HIGH and DONE, and SHALL reset into IDLE.
REQ-013 start SHALL be accepted in IDLE or DONE.
- On acceptance: latch a, b and borrow_start into internal operand registers and go to LOW.
REQ-014 start in LOW or HIGH SHALL be ignored; the operand registers SHALL NOT change.
REQ-015 LOW SHALL compute the latched low nibble minus b[3:0] minus the latched borrow through a 4-bit ripple of full-subtractor cells.
- The low nibble and the internal nibble borrow are stored internally; go to HIGH.
REQ-016 HIGH SHALL compute the high nibble with the internal nibble borrow as borrow-in, through the same 4-bit ripple structure.
- Load diff[7:0] and borrow atomically; go to DONE.
REQ-017 diff and borrow SHALL change only on the HIGH-to-DONE edge and SHALL hold between operations; no partial result is ever visible.
REQ-018 done SHALL be 1 exactly while in DONE.
REQ-019 DONE SHALL go to IDLE when start=0, and to LOW when start=1 (back-to-back operation).
REQ-020 Latency: start sampled at edge N gives done=1 in the cycle after edge N+2.
- Back-to-back throughput: one result per 3 cycles.
REQ-021 Input changes on a, b or borrow_start after acceptance SHALL NOT affect the result in progress.

Reset
REQ-022 rst=1 at an edge SHALL force: state IDLE, diff=8'h00, borrow=0, busy=0, done=0, and clear the internal registers.
- This applies in every state, including mid-operation.
REQ-023 An operation interrupted by reset SHALL produce no done pulse.
REQ-024 start asserted in the same cycle as rst SHALL be ignored.

Configuration
REQ-025 With macro SUB8_OVF_FLAG_EN defined, the block SHALL add output port ovf (1 bit, reset 0).
- ovf = (a[7] != b[7]) && (diff[7] != a[7]), using the latched operands.
- ovf SHALL be registered on the same edge as diff and held with it.
REQ-026 Without SUB8_OVF_FLAG_EN, the ovf port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-027 a=8'h50, b=8'h20, borrow_start=0, start pulse -> done after 3 edges; diff=8'h30, borrow=0 (ovf=0).
REQ-028 a=8'h10, b=8'h01, borrow_start=0 -> diff=8'h0F, borrow=0, which exercises the nibble borrow; a=8'h00, b=8'h01 -> diff=8'hFF, borrow=1.
REQ-029 a=8'h10, b=8'h00, borrow_start=1 -> diff=8'h0F, borrow=0; a=8'h80, b=8'h01 -> diff=8'h7F, borrow=0, ovf=1 when SUB8_OVF_FLAG_EN is defined.
REQ-030 Change a and b and pulse start while busy -> result reflects the first operands only; there is exactly one done pulse.
REQ-031 start held high continuously -> done pulses every 3 cycles; diff is stable between pulses.
REQ-032 rst in HIGH -> next cycle in IDLE with diff=0, borrow=0, done=0; no done pulse follows.
